inv_line_uart_rx: RTL

// - Serial receiver for an 8N1/8E1 UART line driven through a CMOS inverter stage (inverted levels: idle=0, start=1).
// - Synchronizes the line, restores polarity, deglitches the start bit, deframes LSB-first data and flags errors.
// - Presents each byte on a one-entry valid/ready output buffer to the downstream logic.
// - Sits between the inverting line-driver cell and the byte-consuming logic.

---
 rtl/inv_line_uart_rx_pkg.sv | 22 ++
 rtl/inv_line_uart_rx_if.sv | 23 ++
 rtl/inv_line_uart_rx_line_sync.sv | 26 ++
 rtl/inv_line_uart_rx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/inv_line_uart_rx_pkg.sv
// Shared definitions for the inverted-line UART receiver: FSM states,
// default timing and the even-parity helper.
package inv_line_uart_rx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Payloads narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/inv_line_uart_rx_if.sv
// Byte output buffer handshake between the receiver and its consumer.
interface inv_line_uart_rx_if
    import inv_line_uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/inv_line_uart_rx_line_sync.sv
// Synchronizer chain for the raw serial line followed by polarity restore;
// flops reset to the raw idle level so the output reads idle (1) during reset.
module line_sync_inv #(
    parameter int SYNC_STAGES = 2,
    parameter int LINE_INVERT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic s
);
    localparam logic INV      = (LINE_INVERT != 0);
    localparam logic IDLE_RAW = ~INV;

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], line};
        end
    end

    assign s = chain[SYNC_STAGES-1] ^ INV;
endmodule

// File: rtl/inv_line_uart_rx.sv
// UART receiver for an inverted (or normal) line: start deglitch, LSB-first
// deframing, optional even parity, break hold-off and a one-entry output buffer.
module inv_line_uart_rx
    import inv_line_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 1,
    parameter int LINE_INVERT  = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_line,
    inv_line_uart_rx_if.master  byte_if,
    output logic                busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_BITS - 1);

    logic                 s, s_prev;
    rx_state_t            state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 par_bad, par_bad_nx;
    logic                 byte_done, frame_bad;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, par_err_q, frame_err_q, overrun_q;

    line_sync_inv #(
        .SYNC_STAGES (SYNC_STAGES),
        .LINE_INVERT (LINE_INVERT)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (rx_line),
        .s     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s_prev  <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_nx;
            s_prev  <= s;
            cnt     <= cnt_nx;
            bit_cnt <= bit_nx;
            shreg   <= shreg_nx;
            par_bad <= par_bad_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_nx     = bit_cnt;
        shreg_nx   = shreg;
        par_bad_nx = par_bad;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!s && s_prev) begin
                    state_nx = ST_START;
                    cnt_nx   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    if (s) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx   = ST_DATA;
                        bit_nx     = '0;
                        par_bad_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    shreg_nx = {s, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_IDX_LAST) begin
                        state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_nx = bit_cnt + BW'(1);
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx     = '0;
                    par_bad_nx = s ^ even_parity(9'(shreg));
                    state_nx   = ST_STOP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (s) begin
                        byte_done = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nx  = ST_BREAK;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_BREAK: begin
                if (s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A completing byte may land in the same cycle the old one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            if (byte_done) begin
                if (!valid_q || byte_if.rx_ready) begin
                    data_q    <= shreg;
                    par_err_q <= par_bad;
                    valid_q   <= 1'b1;
                    overrun_q <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && byte_if.rx_ready) begin
                valid_q   <= 1'b0;
                par_err_q <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign byte_if.rx_data    = data_q;
    assign byte_if.rx_valid   = valid_q;
    assign byte_if.parity_err = par_err_q;
    assign byte_if.frame_err  = frame_err_q;
    assign byte_if.overrun    = overrun_q;
    assign busy               = (state != ST_IDLE);
endmodule
